// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared state encoding and default sizing for mem_responder
package mem_responder_pkg;
  localparam int MEM_DEPTH_LOG2 = 12;
  localparam int MEM_LATENCY    = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - single-port word RAM with registered read/echo port
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

  // Storage is deliberately outside reset so contents survive RSTN.
  always_ff @(posedge CLK) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Writes echo their data so the response port always reflects the last commit.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)   rdata <= '0;
    else if (en) rdata <= we ? wdata : mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency memory responder; MEM_RESPONDER_STATS_EN adds commit counters
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
  parameter int LATENCY    = MEM_LATENCY
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..255");
  end

  state_t                state;
  logic [7:0]            cnt;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic                  we_q;
  logic [WORD_W-1:0]     wdata_q;
  logic                  accept;
  logic                  commit;
  logic                  addr_unused;

  assign accept      = (state == IDLE) && req_valid && req_ready;
  assign commit      = (state == BUSY) && (cnt == 8'd0);
  assign resp_valid  = (state == RESP);
  assign addr_unused = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            state     <= BUSY;
            req_ready <= 1'b0;
            cnt       <= 8'(LATENCY - 1);
            addr_q    <= req_addr[DEPTH_LOG2+1:2];
            we_q      <= req_we;
            wdata_q   <= req_wdata;
          end
        end
        BUSY: begin
          if (cnt == 8'd0) state <= RESP;
          else             cnt   <= cnt - 8'd1;
        end
        RESP: begin
          if (resp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_responder_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .en    (commit),
    .we    (we_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (resp_rdata)
  );

`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (commit) begin
      if (we_q) wr_count <= wr_count + 32'd1;
      else      rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (LATENCY 4 and 1 instances)
module tb_mem_responder;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RSTN;
  logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
`ifdef MEM_RESPONDER_STATS_EN
  logic [31:0] a_rd_count, a_wr_count, b_rd_count, b_wr_count;
`endif

  mem_responder #(.DEPTH_LOG2(12), .LATENCY(4)) dut_a (
    .CLK(CLK), .RSTN(RSTN),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .req_we(a_req_we), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(a_rd_count), .wr_count(a_wr_count)
`endif
  );

  mem_responder #(.DEPTH_LOG2(12), .LATENCY(1)) dut_b (
    .CLK(CLK), .RSTN(RSTN),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .req_we(b_req_we), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata)
`ifdef MEM_RESPONDER_STATS_EN
    , .rd_count(b_rd_count), .wr_count(b_wr_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  logic watch = 1'b0;
  logic pulsed;
  always @(posedge CLK) begin
    if (!watch)            pulsed <= 1'b0;
    else if (a_resp_valid) pulsed <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      a_req_valid = v; a_req_we = we; a_req_addr = a; a_req_wdata = d;
    end else begin
      b_req_valid = v; b_req_we = we; b_req_addr = a; b_req_wdata = d;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? a_req_ready : b_req_ready;
  endfunction
  function automatic logic vld(input int sel);
    return (sel == 0) ? a_resp_valid : b_resp_valid;
  endfunction
  function automatic logic [31:0] rd(input int sel);
    return (sel == 0) ? a_resp_rdata : b_resp_rdata;
  endfunction

  // One request with resp_ready held high; cyc = edges from acceptance to handshake.
  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp,
                     input string name, output int cyc);
    int w = 0;
    int lat = (sel == 0) ? 4 : 1;
    while (!rdy(sel) && w < 50) begin @(posedge CLK); #1; w++; end
    chk({name, " req_ready"}, 32'(rdy(sel)), 32'd1);
    drive(sel, 1'b1, we, addr, wdata);
    exp_q.push_back(exp);
    @(posedge CLK); #1;
    drive(sel, 1'b0, ~we, $urandom, $urandom);
    cyc = 0;
    while (!vld(sel) && cyc < 300) begin @(posedge CLK); #1; cyc++; end
    chk({name, " latency"}, 32'(cyc), 32'(lat));
    chk({name, " rdata"}, rd(sel), exp_q.pop_front());
    @(posedge CLK); #1;
    cyc++;
    chk({name, " release"}, {30'd0, vld(sel), rdy(sel)}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, total;
    logic held_ok;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_0011, 32'h0,         32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'h0000_4010, 32'h0,         32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 32'h0000_3FFC, 32'h55AA_1234, 32'h55AA_1234};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         32'h55AA_1234};
    vecs[6] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
    vecs[7] = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[8] = '{1'b0, 32'h0001_0002, 32'h0,         32'h0000_0001};
    vecs[9] = '{1'b0, 32'h0000_0017, 32'h0,         32'hCAFE_F00D};

    RSTN = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    a_resp_ready = 1'b1;
    b_resp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset req_ready", 32'(a_req_ready), 32'd0);
    chk("reset resp_valid", 32'(a_resp_valid), 32'd0);
    chk("reset resp_rdata", a_resp_rdata, 32'd0);
    RSTN = 1'b1;
    #1;
    chk("req_ready before edge", 32'(a_req_ready), 32'd0);
    @(posedge CLK); #1;
    chk("req_ready after edge", 32'(a_req_ready), 32'd1);

    foreach (vecs[i])
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i), cyc);

    // Response held under backpressure for 10 cycles.
    a_resp_ready = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    @(posedge CLK); #1;
    drive(0, 1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111);
    cyc = 0;
    while (!a_resp_valid && cyc < 300) begin @(posedge CLK); #1; cyc++; end
    chk("bp latency", 32'(cyc), 32'd4);
    held_ok = 1'b1;
    repeat (10) begin
      @(posedge CLK); #1;
      if (!a_resp_valid || a_resp_rdata !== 32'hDEAD_BEEF || a_req_ready) held_ok = 1'b0;
    end
    chk("bp hold stable", 32'(held_ok), 32'd1);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    a_resp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("bp release", {30'd0, a_resp_valid, a_req_ready}, 32'd1);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "bp no write", cyc);

    // Reset during BUSY abandons the write.
    txn(0, 1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 32'hAAAA_AAAA, "pre abort", cyc);
    watch = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    @(posedge CLK); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
    RSTN = 1'b0;
    #1;
    chk("abort resp_valid", 32'(a_resp_valid), 32'd0);
    chk("abort req_ready", 32'(a_req_ready), 32'd0);
    repeat (6) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    @(posedge CLK); #1;
    chk("abort no pulse", 32'(pulsed), 32'd0);
    watch = 1'b0;
    txn(0, 1'b0, 32'h0000_0020, 32'h0, 32'hAAAA_AAAA, "after abort", cyc);

    // LATENCY=1 back-to-back reads.
    for (int i = 0; i < 8; i++)
      txn(1, 1'b1, 32'(i * 4), 32'hC0DE_0000 | 32'(i), 32'hC0DE_0000 | 32'(i), $sformatf("b wr%0d", i), cyc);
    total = 0;
    for (int i = 0; i < 8; i++) begin
      txn(1, 1'b0, 32'(i * 4), 32'h0, 32'hC0DE_0000 | 32'(i), $sformatf("b rd%0d", i), cyc);
      total += cyc;
    end
    chk("b 8 reads cycles", 32'(total), 32'd16);

`ifdef MEM_RESPONDER_STATS_EN
    RSTN = 1'b0;
    @(posedge CLK); #1;
    chk("stats rd reset", a_rd_count, 32'd0);
    chk("stats wr reset", a_wr_count, 32'd0);
    RSTN = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++)
      txn(0, 1'b1, 32'h100 + 32'(i * 4), 32'h5000 + 32'(i), 32'h5000 + 32'(i), $sformatf("st wr%0d", i), cyc);
    for (int i = 0; i < 5; i++)
      txn(0, 1'b0, 32'h100 + 32'((i % 3) * 4), 32'h0, 32'h5000 + 32'(i % 3), $sformatf("st rd%0d", i), cyc);
    chk("stats rd_count", a_rd_count, 32'd5);
    chk("stats wr_count", a_wr_count, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Main-memory responder for the 2-way set-associative cache's miss path. It accepts one word-sized read or write request from the cache controller over a valid/ready handshake. It services the request against an internal word-addressed memory after a fixed, parameterised latency, and returns one response over a second valid/ready handshake. It is the memory end of the cache-to-memory refill/writeback interface, used as the backing store in simulation and synthesis.

## Interface
Parameters:
- `DEPTH_LOG2`, default 12: memory holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 4: cycles from request acceptance to response valid. Legal range 1–255; elaboration error outside it.

Ports:
- `CLK` input, 1 bit: single clock; all state changes on the rising edge.
- `RSTN` input, 1 bit: reset, asynchronous and active-low.
- `req_valid` input, 1 bit: the cache presents a request.
- `req_ready` output, 1 bit: the responder can accept a request.
- `req_addr` input, 32 bits: byte address.
- `req_we` input, 1 bit: 1 = write, 0 = read.
- `req_wdata` input, 32 bits: write data.
- `resp_valid` output, 1 bit: response available.
- `resp_ready` input, 1 bit: the cache accepts the response.
- `resp_rdata` output, 32 bits: read data, or echoed write data.

## Operation
- Word index is `req_addr[DEPTH_LOG2+1:2]`.
  - Bits [1:0] are ignored.
  - Bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo 2^DEPTH_LOG2 words.
- FSM states are IDLE, BUSY and RESP.
  - IDLE: `req_ready`=1. When `req_valid`&&`req_ready` at an edge, the block latches addr, we and wdata, loads the down-counter with LATENCY-1, and moves to BUSY.
  - BUSY: `req_ready`=0. The counter decrements each edge. On the edge where the counter is 0, the access commits and the FSM moves to RESP.
    - Write commit: the memory word is updated and `resp_rdata` takes wdata.
    - Read commit: `resp_rdata` takes the memory word.
  - RESP: `resp_valid`=1 and `resp_rdata` is stable. On the edge where `resp_ready`=1, the FSM moves to IDLE. While `resp_ready`=0, the response is held indefinitely.
- One outstanding request at most; there is no pipelining and no queueing.
- Inputs are sampled only at the acceptance edge. Changes to req_* while BUSY or RESP are ignored.
- `resp_rdata` holds its last value outside RESP.

## Timing
- Reset (RSTN low, asynchronous):
  - FSM goes to IDLE and the counter to 0.
  - `req_ready`=0, `resp_valid`=0, `resp_rdata`=0.
- `req_ready` is registered. It rises on the first CLK edge after RSTN deasserts.
- Memory contents are not reset; they are undefined until written.
- Latency: a request accepted at edge N gives `resp_valid` high after edge N+LATENCY.
- Response handshake at edge M: `resp_valid` falls and `req_ready` rises after edge M. The next request can be accepted at edge M+1.
- With `resp_ready` tied high, throughput is one request per LATENCY+1 cycles.
- Reset mid-operation:
  - During BUSY, the request is abandoned and no write commits.
  - During RESP, the response is dropped.
  - Written memory contents are retained.
- Read-after-write to the same word returns the newly written data.

## Configuration
- Macro `MEM_RESPONDER_STATS_EN`.
- Defined:
  - Adds output ports `rd_count` and `wr_count`, 32 bits each.
  - Each counter increments by 1 on its commit edge.
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

## Structure
- Package `mem_responder_pkg` holds:
  - the state enum (IDLE, BUSY, RESP);
  - default constants MEM_DEPTH_LOG2=12 and MEM_LATENCY=4;
  - the word width, 32.
- Sub-module `mem_responder_array`: single-port synchronous RAM of 2^DEPTH_LOG2×32 with inputs we, addr, wdata and registered rdata. The top-level FSM drives it only on the commit edge.

## Test plan
- Reset then idle:
  - During reset: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0.
  - `req_ready`=1 one edge after RSTN rises.
- Write then read, LATENCY=4:
  - Write 0xDEADBEEF to 0x00000010. `resp_valid` rises 4 cycles after acceptance with rdata 0xDEADBEEF.
  - Read 0x00000010, 0x00000011 and 0x00004010 (alias, DEPTH_LOG2=12). Each returns 0xDEADBEEF after 4 cycles.
- Response backpressure:
  - Hold `resp_ready`=0 for 10 cycles. `resp_valid` and `resp_rdata` stay stable and `req_ready` stays 0.
  - Raise `resp_ready`. `req_ready`=1 on the next cycle.
- LATENCY=1 back-to-back with `resp_ready`=1: 8 sequential reads complete in exactly 16 cycles, with the correct data each time.
- Reset mid-BUSY:
  - Write 0x12345678 to a word holding 0xAAAAAAAA and assert RSTN low during BUSY.
  - After reset, a read of that word returns 0xAAAAAAAA and `resp_valid` never pulsed for the aborted request.
- With `MEM_RESPONDER_STATS_EN`: after 3 writes and 5 reads, `rd_count`=5 and `wr_count`=3. Both read 0 after reset.
